// File: rtl/can_destuffer.sv
// can_destuffer: samples CAN rx at baud sample points, tracks bus state and strips stuff bits
module can_destuffer #(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_RUN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic baud,
  input  logic lock,
  input  logic rx,
  input  logic stuff_en,
  output logic bit_valid,
  output logic bit_data,
  output logic sof,
  output logic stuff_drop,
  output logic stuff_err,
  output logic sync_err,
  output logic bus_idle,
  output logic in_frame
);
  localparam int RW = $clog2(IDLE_BITS + 1);
  typedef enum logic [1:0] {INTEGRATE, IDLE, FRAME, ERROR} state_t;
  state_t state, state_nxt;
  logic baud_q, tick, lock_loss, rec_full;
  logic last_bit, last_nxt;
  logic [2:0] run_len, run_nxt;
  logic [RW-1:0] rec_cnt, rec_nxt;
  logic valid_nxt, data_nxt, sof_nxt, drop_nxt, serr_nxt;
  assign tick      = baud & ~baud_q;
  assign lock_loss = (state == FRAME) && !lock;
  assign rec_nxt   = (lock_loss || !tick) ? rec_cnt :
                     !rx ? '0 :
                     (rec_cnt == RW'(IDLE_BITS)) ? rec_cnt : rec_cnt + 1'b1;
  assign rec_full  = tick && !lock_loss && (rec_nxt == RW'(IDLE_BITS));
  assign bus_idle  = (state == IDLE);
  assign in_frame  = (state == FRAME);
  // state, datapath and strobe registers; strobes default low so each lasts one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INTEGRATE;
      baud_q     <= 1'b0;
      run_len    <= '0;
      last_bit   <= 1'b1;
      rec_cnt    <= '0;
      bit_valid  <= 1'b0;
      bit_data   <= 1'b0;
      sof        <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_q     <= baud;
      run_len    <= run_nxt;
      last_bit   <= last_nxt;
      rec_cnt    <= rec_nxt;
      bit_valid  <= valid_nxt;
      bit_data   <= data_nxt;
      sof        <= sof_nxt;
      stuff_drop <= drop_nxt;
      stuff_err  <= serr_nxt;
      sync_err   <= lock_loss;
    end
  end
  // next-state: lock loss in FRAME preempts any coincident sample
  always_comb begin
    state_nxt = state;
    if (lock_loss)
      state_nxt = ERROR;
    else if (tick)
      case (state)
        INTEGRATE: state_nxt = rec_full ? IDLE : INTEGRATE;
        IDLE:      state_nxt = rx ? IDLE : lock ? FRAME : INTEGRATE;
        FRAME:     state_nxt = stuff_en ? ((run_len == 3'(STUFF_RUN) && rx == last_bit) ? ERROR : FRAME)
                                        : (rec_full ? IDLE : FRAME);
        default:   state_nxt = rec_full ? IDLE : ERROR;
      endcase
  end
  // per-sample outputs and run tracking; a removed stuff bit starts the next run
  always_comb begin
    valid_nxt = 1'b0;
    data_nxt  = rx;
    sof_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    serr_nxt  = 1'b0;
    run_nxt   = run_len;
    last_nxt  = last_bit;
    if (tick && !lock_loss) begin
      if (state == IDLE && !rx && lock) begin
        valid_nxt = 1'b1;
        sof_nxt   = 1'b1;
        run_nxt   = 3'd1;
        last_nxt  = 1'b0;
      end else if (state == FRAME && !stuff_en) begin
        valid_nxt = 1'b1;
        run_nxt   = '0;
        last_nxt  = rx;
      end else if (state == FRAME && run_len == 3'(STUFF_RUN)) begin
        drop_nxt  = rx != last_bit;
        serr_nxt  = rx == last_bit;
        run_nxt   = 3'd1;
        last_nxt  = rx;
      end else if (state == FRAME) begin
        valid_nxt = 1'b1;
        run_nxt   = (rx != last_bit) ? 3'd1 : (run_len == 3'(STUFF_RUN)) ? run_len : run_len + 3'd1;
        last_nxt  = rx;
      end
    end
  end
endmodule

// File: tb/tb_can_destuffer.sv
// tb_can_destuffer: directed scenario tests for can_destuffer
module tb_can_destuffer;
  logic clk = 0, rst = 1, baud = 0, lock = 1, rx = 1, stuff_en = 1;
  logic bit_valid, bit_data, sof, stuff_drop, stuff_err, sync_err, bus_idle, in_frame;
  logic v, d, s, dr, se, sy;
  int checks = 0, errors = 0, linger = 0;

  can_destuffer dut (
    .clk(clk), .rst(rst), .baud(baud), .lock(lock), .rx(rx), .stuff_en(stuff_en),
    .bit_valid(bit_valid), .bit_data(bit_data), .sof(sof), .stuff_drop(stuff_drop),
    .stuff_err(stuff_err), .sync_err(sync_err), .bus_idle(bus_idle), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  // one baud period: rising edge, capture strobes just after it, then confirm they fell
  task automatic send(input logic b);
    @(negedge clk); rx = b; baud = 1;
    @(posedge clk); #1;
    v = bit_valid; d = bit_data; s = sof; dr = stuff_drop; se = stuff_err; sy = sync_err;
    @(negedge clk); baud = 0;
    @(posedge clk); #1;
    if (bit_valid | sof | stuff_drop | stuff_err | sync_err) linger++;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bit_valid, bit_data, sof, stuff_drop, stuff_err, sync_err, bus_idle, in_frame} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000000",
        {bit_valid, bit_data, sof, stuff_drop, stuff_err, sync_err, bus_idle, in_frame});
    end
    @(negedge clk); rst = 0;
    for (int i = 1; i <= 11; i++) begin
      send(1);
      checks++;
      if (bus_idle !== (i == 11)) begin
        errors++; $display("FAIL integrate_idle tick %0d: bus_idle=%b want %b", i, bus_idle, i == 11);
      end
      checks++;
      if (v !== 1'b0) begin
        errors++; $display("FAIL integrate_no_valid tick %0d: bit_valid=%b want 0", i, v);
      end
    end
  endtask

  task automatic test_sof_stuff;
    logic [6:0] bits = 7'b0000011;
    logic [4:0] exp [7] = '{5'b10100, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00010, 5'b11000};
    for (int i = 0; i < 7; i++) begin
      send(bits[6-i]);
      checks++;
      if ({v, v & d, s, dr, se} !== exp[i]) begin
        errors++; $display("FAIL sof_stuff bit %0d: {valid,data,sof,drop,err}=%b want %b", i + 1, {v, v & d, s, dr, se}, exp[i]);
      end
    end
    checks++;
    if (in_frame !== 1'b1) begin
      errors++; $display("FAIL sof_in_frame: in_frame=%b want 1", in_frame);
    end
  endtask

  task automatic test_stuff_err;
    send(0);
    checks++;
    if ({v, d} !== 2'b10) begin
      errors++; $display("FAIL stuff_err_lead: {valid,data}=%b want 10", {v, d});
    end
    for (int i = 1; i <= 6; i++) begin
      send(1);
      checks++;
      if ({v, v & d, dr, se} !== ((i < 6) ? 4'b1100 : 4'b0001)) begin
        errors++; $display("FAIL stuff_err bit %0d: {valid,data,drop,err}=%b want %b", i, {v, v & d, dr, se}, (i < 6) ? 4'b1100 : 4'b0001);
      end
    end
    checks++;
    if (in_frame !== 1'b0) begin
      errors++; $display("FAIL stuff_err_left_frame: in_frame=%b want 0", in_frame);
    end
    for (int i = 0; i < 11; i++) send(1);
    checks++;
    if (bus_idle !== 1'b1) begin
      errors++; $display("FAIL stuff_err_recover: bus_idle=%b want 1", bus_idle);
    end
  endtask

  task automatic test_no_stuff;
    send(0);
    checks++;
    if (s !== 1'b1) begin
      errors++; $display("FAIL no_stuff_sof: sof=%b want 1", s);
    end
    stuff_en = 0;
    for (int i = 1; i <= 11; i++) begin
      send(1);
      checks++;
      if ({v, d, se, dr} !== 4'b1100) begin
        errors++; $display("FAIL no_stuff bit %0d: {valid,data,err,drop}=%b want 1100", i, {v, d, se, dr});
      end
      checks++;
      if ({bus_idle, in_frame} !== ((i == 11) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL no_stuff_state bit %0d: {idle,frame}=%b want %b", i, {bus_idle, in_frame}, (i == 11) ? 2'b10 : 2'b01);
      end
    end
    stuff_en = 1;
  endtask

  task automatic test_sync_err;
    send(0); send(1); send(0);
    @(negedge clk); rx = 0; baud = 1; lock = 0;
    @(posedge clk); #1;
    checks++;
    if ({sync_err, bit_valid, in_frame} !== 3'b100) begin
      errors++; $display("FAIL sync_err: {sync,valid,frame}=%b want 100", {sync_err, bit_valid, in_frame});
    end
    @(negedge clk); baud = 0;
    @(posedge clk); #1;
    checks++;
    if (sync_err !== 1'b0) begin
      errors++; $display("FAIL sync_err_width: sync_err=%b want 0", sync_err);
    end
    lock = 1;
    for (int i = 0; i < 11; i++) send(1);
    checks++;
    if (bus_idle !== 1'b1) begin
      errors++; $display("FAIL sync_err_recover: bus_idle=%b want 1", bus_idle);
    end
  endtask

  task automatic test_rst_mid;
    send(0);
    @(negedge clk); rx = 0; baud = 1;
    @(posedge clk); #1;
    checks++;
    if (bit_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_valid: bit_valid=%b want 1", bit_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({bit_valid, bit_data, sof, stuff_drop, stuff_err, sync_err, bus_idle, in_frame} !== 8'h00) begin
      errors++; $display("FAIL rst_async: got %b want 00000000",
        {bit_valid, bit_data, sof, stuff_drop, stuff_err, sync_err, bus_idle, in_frame});
    end
    @(negedge clk); baud = 0; rst = 0;
    send(0);
    checks++;
    if ({v, s} !== 2'b00) begin
      errors++; $display("FAIL rst_no_sof: {valid,sof}=%b want 00", {v, s});
    end
    for (int i = 0; i < 10; i++) send(1);
    checks++;
    if (bus_idle !== 1'b0) begin
      errors++; $display("FAIL rst_integrate_10: bus_idle=%b want 0", bus_idle);
    end
    send(1);
    checks++;
    if (bus_idle !== 1'b1) begin
      errors++; $display("FAIL rst_integrate_11: bus_idle=%b want 1", bus_idle);
    end
    send(0);
    checks++;
    if ({v, s} !== 2'b11) begin
      errors++; $display("FAIL rst_sof_again: {valid,sof}=%b want 11", {v, s});
    end
  endtask

  task automatic test_strobe_width;
    checks++;
    if (linger !== 0) begin
      errors++; $display("FAIL strobe_width: %0d strobes lasted past one clk, want 0", linger);
    end
  endtask

  initial begin
    test_reset;
    test_sof_stuff;
    test_stuff_err;
    test_no_stuff;
    test_sync_err;
    test_rst_mid;
    test_strobe_width;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
